led_matrix_scanner: RTL and testbench

Parametrised successor to the fixed 4x4 binary-clock display driver. It time-multiplexes a ROWS x COLS LED matrix with per-row dwell, anti-ghost blanking, global PWM brightness and a double-buffered frame. A producer (clock datapath) writes a frame at any time. The new frame is shown only from the next frame boundary, so the display never tears.

---
 rtl/led_matrix_scanner_pkg.sv | 15 +
 rtl/led_matrix_scanner_scan_timer.sv | 57 +++++
 rtl/led_matrix_scanner.sv | 124 ++++++++++++
 tb/tb_led_matrix_scanner.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_scanner_pkg.sv
// Shared helpers for the LED matrix scanner: counter width sizing and
// inactive output levels derived from the line polarity settings.
package led_matrix_scanner_pkg;

  // Counter width for a modulus n; a modulus of 1 still gets one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Idle level of a line: active-low lines idle high, active-high lines idle low.
  function automatic logic idle_level(input int active_low);
    return (active_low != 0);
  endfunction

endpackage

// File: rtl/led_matrix_scanner_scan_timer.sv
// Row/tick scan counter. Exposes the state the next edge will load, plus a
// flag marking that edge as a frame boundary (entering row 0, tick 0).
module scan_timer
  import led_matrix_scanner_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int DWELL  = 8,
  parameter int ROW_W  = cnt_w(ROWS),
  parameter int TICK_W = cnt_w(DWELL)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic [ROW_W-1:0]  row_nxt,
  output logic [TICK_W-1:0] tick_nxt,
  output logic              boundary
);

  logic [ROW_W-1:0]  row;
  logic [TICK_W-1:0] tick;
  logic              run;

  // While disabled the counters sit at zero; the first enabled edge re-enters
  // the frame start even though the count value itself does not change.
  always_comb begin
    row_nxt  = '0;
    tick_nxt = '0;
    boundary = 1'b0;
    if (enable) begin
      if (!run) begin
        boundary = 1'b1;
      end else if (tick == TICK_W'(DWELL - 1)) begin
        if (row == ROW_W'(ROWS - 1)) begin
          boundary = 1'b1;
        end else begin
          row_nxt = row + ROW_W'(1);
        end
      end else begin
        row_nxt  = row;
        tick_nxt = tick + TICK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row  <= '0;
      tick <= '0;
      run  <= 1'b0;
    end else begin
      row  <= row_nxt;
      tick <= tick_nxt;
      run  <= enable;
    end
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// Time-multiplexed ROWS x COLS LED matrix driver with blanking, global PWM
// brightness and a double-buffered frame swapped only at frame boundaries.
module led_matrix_scanner
  import led_matrix_scanner_pkg::*;
#(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int DWELL          = 8,
  parameter int BLANK          = 1,
  parameter int BRIGHT_W       = 3,
  parameter int ROW_ACTIVE_LOW = 1,
  parameter int COL_ACTIVE_LOW = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [ROWS*COLS-1:0] pixels,
  input  logic                 load,
  input  logic [BRIGHT_W-1:0]  bright,
  output logic [ROWS-1:0]      row_out,
  output logic [COLS-1:0]      col_out,
  output logic                 frame_start,
  output logic                 pending
);

  localparam int N      = ROWS * COLS;
  localparam int ROW_W  = cnt_w(ROWS);
  localparam int TICK_W = cnt_w(DWELL);
  localparam logic [ROWS-1:0] ROW_IDLE = {ROWS{idle_level(ROW_ACTIVE_LOW)}};
  localparam logic [COLS-1:0] COL_IDLE = {COLS{idle_level(COL_ACTIVE_LOW)}};

  logic [ROW_W-1:0]  row_nxt;
  logic [TICK_W-1:0] tick_nxt;
  logic              boundary;
  logic [N-1:0]      active;
  logic [N-1:0]      active_nxt;
  logic [N-1:0]      pend_buf;
  logic [ROWS-1:0]   row_on;
  logic [COLS-1:0]   col_on;
  logic              lit;

  // Number of lit cycles per slot: brightness clamped to the unblanked span.
  function automatic int on_limit(input logic [BRIGHT_W-1:0] b);
    int span;
    span = DWELL - BLANK;
    return (int'(b) < span) ? int'(b) : span;
  endfunction

  scan_timer #(
    .ROWS   (ROWS),
    .DWELL  (DWELL),
    .ROW_W  (ROW_W),
    .TICK_W (TICK_W)
  ) u_scan_timer (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .row_nxt  (row_nxt),
    .tick_nxt (tick_nxt),
    .boundary (boundary)
  );

  // A load on the boundary edge bypasses the pending buffer so row 0 shows it at once.
  always_comb begin
    active_nxt = active;
    if (boundary) begin
      if (load) begin
        active_nxt = pixels;
      end else if (pending) begin
        active_nxt = pend_buf;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active   <= '0;
      pend_buf <= '0;
      pending  <= 1'b0;
    end else begin
      active <= active_nxt;
      if (load) begin
        pend_buf <= pixels;
      end
      if (boundary) begin
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // Decode the slot about to be entered so the registered outputs line up with it.
  always_comb begin
    row_on = '0;
    col_on = '0;
    lit    = 1'b0;
    if (enable && (int'(tick_nxt) >= BLANK)) begin
      lit = (int'(tick_nxt) - BLANK) < on_limit(bright);
      for (int r = 0; r < ROWS; r++) begin
        if (int'(row_nxt) == r) begin
          row_on[r] = 1'b1;
          if (lit) begin
            col_on = active_nxt[r*COLS +: COLS];
          end
        end
      end
    end
  end

  // Polarity is applied only here; XOR with the idle level flips active-low lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_out     <= ROW_IDLE;
      col_out     <= COL_IDLE;
      frame_start <= 1'b0;
    end else begin
      row_out     <= row_on ^ ROW_IDLE;
      col_out     <= col_on ^ COL_IDLE;
      frame_start <= boundary;
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner: default 4x4/DWELL 8/BLANK 1 instance plus a
// DWELL 4/BLANK 0 instance sharing stimulus, both tracked by a reference model.
module tb_led_matrix_scanner;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] pixels;
  logic        load;
  logic [2:0]  bright;

  logic [3:0] row0, col0, row1, col1;
  logic       fs0, pend0, fs1, pend1;

  int n_cmp = 0;
  int n_bad = 0;

  led_matrix_scanner dut0 (
    .clk(clk), .rst(rst), .enable(enable), .pixels(pixels), .load(load),
    .bright(bright), .row_out(row0), .col_out(col0), .frame_start(fs0),
    .pending(pend0)
  );

  led_matrix_scanner #(.DWELL(4), .BLANK(0)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .pixels(pixels), .load(load),
    .bright(bright), .row_out(row1), .col_out(col1), .frame_start(fs1),
    .pending(pend1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position within the frame as a single cycle index.
  int          DW[2] = '{8, 4};
  int          BL[2] = '{1, 0};
  int          pos[2];
  bit          run[2];
  logic [15:0] act[2];
  logic [15:0] pbuf[2];
  logic        pnd[2];
  logic [3:0]  e_row[2];
  logic [3:0]  e_col[2];
  logic        e_fs[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      pos[k] = 0; run[k] = 0; act[k] = '0; pbuf[k] = '0; pnd[k] = 1'b0;
      e_row[k] = 4'hF; e_col[k] = 4'h0; e_fs[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int  period, r, t, lim;
      bit  bnd;
      period = 4 * DW[k];
      bnd = enable && (!run[k] || pos[k] == period - 1);
      if (bnd) begin
        if (load) act[k] = pixels;
        else if (pnd[k]) act[k] = pbuf[k];
        pnd[k] = 1'b0;
      end else if (load) begin
        pnd[k] = 1'b1;
      end
      if (load) pbuf[k] = pixels;
      if (enable) begin
        pos[k] = run[k] ? (pos[k] + 1) % period : 0;
        run[k] = 1;
      end else begin
        pos[k] = 0;
        run[k] = 0;
      end
      r = pos[k] / DW[k];
      t = pos[k] % DW[k];
      lim = (int'(bright) < DW[k] - BL[k]) ? int'(bright) : DW[k] - BL[k];
      e_row[k] = 4'hF;
      e_col[k] = 4'h0;
      if (enable && t >= BL[k]) begin
        e_row[k][r] = 1'b0;
        if (t - BL[k] < lim) e_col[k] = act[k][r*4 +: 4];
      end
      e_fs[k] = bnd;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("d0.row", 32'(row0), 32'(e_row[0]));
    check("d0.col", 32'(col0), 32'(e_col[0]));
    check("d0.fs", 32'(fs0), 32'(e_fs[0]));
    check("d0.pend", 32'(pend0), 32'(pnd[0]));
    check("d1.row", 32'(row1), 32'(e_row[1]));
    check("d1.col", 32'(col1), 32'(e_col[1]));
    check("d1.fs", 32'(fs1), 32'(e_fs[1]));
    check("d1.pend", 32'(pend1), 32'(pnd[1]));
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  // Holds load only for the first of n cycles.
  task automatic step(input int n);
    cycle();
    load = 1'b0;
    for (int i = 1; i < n; i++) cycle();
  endtask

  task automatic exp0(input string nm, input logic [3:0] r, input logic [3:0] c,
                      input logic fs, input logic pd);
    check({nm, ".row"}, 32'(row0), 32'(r));
    check({nm, ".col"}, 32'(col0), 32'(c));
    check({nm, ".fs"}, 32'(fs0), 32'(fs));
    check({nm, ".pend"}, 32'(pend0), 32'(pd));
  endtask

  task automatic async_reset(input string nm);
    rst = 1'b1;
    #2;
    exp0({nm, ".d0"}, 4'hF, 4'h0, 1'b0, 1'b0);
    check({nm, ".d1.row"}, 32'(row1), 32'hF);
    check({nm, ".d1.col"}, 32'(col1), 32'h0);
    check({nm, ".d1.pend"}, 32'(pend1), 32'h0);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        en;
    logic        ld;
    logic [15:0] pix;
    logic [2:0]  br;
    int          n;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        fs;
    logic        pend;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 16'h8421, 3'd7, 1, 4'hF, 4'h0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 16'h8421, 3'd7, 1, 4'hF, 4'h0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 16'h8421, 3'd7, 1, 4'hE, 4'h1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 16'h8421, 3'd7, 6, 4'hE, 4'h1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 16'h8421, 3'd7, 1, 4'hF, 4'h0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 16'h8421, 3'd7, 1, 4'hD, 4'h2, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 16'h8421, 3'd7, 8, 4'hB, 4'h4, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 16'h8421, 3'd7, 8, 4'h7, 4'h8, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 16'h8421, 3'd7, 7, 4'hF, 4'h0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 16'h8421, 3'd3, 3, 4'hE, 4'h1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 16'h8421, 3'd3, 1, 4'hE, 4'h0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 16'h8421, 3'd0, 5, 4'hD, 4'h0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 16'h8421, 3'd7, 1, 4'hF, 4'h0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 16'h8421, 3'd7, 1, 4'hF, 4'h0, 1'b1, 1'b0};

    rst = 1'b1; enable = 1'b0; load = 1'b0; pixels = '0; bright = 3'd7;
    #2;
    exp0("reset", 4'hF, 4'h0, 1'b0, 1'b0);
    model_reset();
    #1;
    rst = 1'b0;

    // Basic scan, brightness and enable, table driven
    for (int i = 0; i < 14; i++) begin
      enable = tbl[i].en; load = tbl[i].ld; pixels = tbl[i].pix; bright = tbl[i].br;
      step(tbl[i].n);
      exp0($sformatf("vec%0d", i), tbl[i].row, tbl[i].col, tbl[i].fs, tbl[i].pend);
    end

    // Load on the boundary edge, then a deferred load while row 2 is shown
    enable = 1'b0; step(1);
    enable = 1'b1; load = 1'b1; pixels = 16'hFFFF; step(1);
    exp0("bypass", 4'hF, 4'h0, 1'b1, 1'b0);
    step(1);  exp0("bypass.r0", 4'hE, 4'hF, 1'b0, 1'b0);
    step(16); exp0("dbuf.r2", 4'hB, 4'hF, 1'b0, 1'b0);
    load = 1'b1; pixels = 16'h0000; step(1);
    exp0("dbuf.load", 4'hB, 4'hF, 1'b0, 1'b1);
    step(7);  exp0("dbuf.r3", 4'h7, 4'hF, 1'b0, 1'b1);
    step(7);  exp0("dbuf.swap", 4'hF, 4'h0, 1'b1, 1'b0);
    step(1);  exp0("dbuf.new", 4'hE, 4'h0, 1'b0, 1'b0);

    // Two loads in one frame: last one wins
    load = 1'b1; pixels = 16'h000F; step(1);
    exp0("twoload.a", 4'hE, 4'h0, 1'b0, 1'b1);
    step(3);
    load = 1'b1; pixels = 16'hF000; step(1);
    step(26); exp0("twoload.swap", 4'hF, 4'h0, 1'b1, 1'b0);
    step(1);  exp0("twoload.r0", 4'hE, 4'h0, 1'b0, 1'b0);
    step(24); exp0("twoload.r3", 4'h7, 4'hF, 1'b0, 1'b0);

    // Disable at row 1 tick 4, re-enable, then reset with a frame pending
    step(19); exp0("en.r1t4", 4'hD, 4'h0, 1'b0, 1'b0);
    enable = 1'b0; step(1); exp0("en.off", 4'hF, 4'h0, 1'b0, 1'b0);
    enable = 1'b1; step(1); exp0("en.restart", 4'hF, 4'h0, 1'b1, 1'b0);
    step(1);  exp0("en.r0", 4'hE, 4'h0, 1'b0, 1'b0);
    load = 1'b1; pixels = 16'h1234; step(1);
    exp0("rst.pend", 4'hE, 4'h0, 1'b0, 1'b1);
    async_reset("midrst");
    step(1);  exp0("rst.start", 4'hF, 4'h0, 1'b1, 1'b0);
    step(25); exp0("rst.dark", 4'h7, 4'h0, 1'b0, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      load   = ($urandom_range(0, 11) == 0);
      pixels = 16'($urandom());
      if ($urandom_range(0, 15) == 0) bright = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 399) == 0) async_reset("rndrst");
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
